// File: rtl/fft_out_serializer_if.sv
// Stream bundle between the FFT output serializer and its neighbours:
// the 16-lane frame input and the one-sample-per-cycle valid/ready output.
interface fft_out_serializer_if #(
   parameter int WIDTH = 13,
   parameter int LANES = 16
);
   logic                    din_en;
   logic signed [WIDTH-1:0] din_re [LANES];
   logic signed [WIDTH-1:0] din_im [LANES];
   logic                    dout_valid;
   logic                    dout_ready;
   logic signed [WIDTH-1:0] dout_re;
   logic signed [WIDTH-1:0] dout_im;
   logic                    dout_first;
   logic                    dout_last;
   logic                    overflow;
   logic                    overflow_clr;

   // Environment side: feeds frames, consumes samples
   modport master (
      output din_en, din_re, din_im, dout_ready, overflow_clr,
      input  dout_valid, dout_re, dout_im, dout_first, dout_last, overflow
   );

   // Serializer side
   modport slave (
      input  din_en, din_re, din_im, dout_ready, overflow_clr,
      output dout_valid, dout_re, dout_im, dout_first, dout_last, overflow
   );
endinterface

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer behind the 512-point FFT: captures 32 beats of
// 16 I/Q lanes per frame into one of two banks and replays each stored
// frame one complex sample per cycle. The input cannot stall, so a frame
// arriving with no free bank is discarded and flagged on sticky overflow.
module fft_out_serializer #(
   parameter int WIDTH  = 13,
   parameter int LANES  = 16,
   parameter int NPOINT = 512
) (
   input  logic                 clk,
   input  logic                 rstn,
   fft_out_serializer_if.slave  bus
);
   localparam int BEATS  = NPOINT / LANES;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int LANE_W = $clog2(LANES);
   localparam int IDX_W  = $clog2(NPOINT);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NPOINT - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   // Bank is the address MSB; each entry packs {re, im}
   logic [2*WIDTH-1:0] mem [2*NPOINT];

   logic [1:0]              full, full_set, full_clr;
   logic                    wr_bank, rd_bank;
   logic [BEAT_W-1:0]       wb;
   logic                    drop, drop_now, wr_keep, wr_done, ovf_set;
   logic                    ovf_q;
   state_t                  state;
   logic [IDX_W-1:0]        rd_idx, idx_nxt;
   logic                    rd_take, rd_done;
   logic                    vld_p1, first_p1, last_p1;
   logic signed [WIDTH-1:0] re_p1, im_p1;

   // Per-cycle write/read decisions shared by the sequential blocks
   always_comb begin
      drop_now = (wb == '0) ? full[wr_bank] : drop;
      wr_keep  = bus.din_en && !drop_now;
      wr_done  = wr_keep && (wb == LAST_BEAT);
      ovf_set  = bus.din_en && (wb == '0) && full[wr_bank];
      rd_take  = vld_p1 && bus.dout_ready;
      rd_done  = rd_take && (rd_idx == LAST_IDX);
      idx_nxt  = rd_idx + IDX_W'(1);
      full_set = '0;
      full_clr = '0;
      if (wr_done) full_set[wr_bank] = 1'b1;
      if (rd_done) full_clr[rd_bank] = 1'b1;
   end

   // Sample storage: all lanes of a kept beat land in one edge
   always_ff @(posedge clk) begin
      if (wr_keep) begin
         for (int k = 0; k < LANES; k++) begin
            mem[{wr_bank, wb, LANE_W'(k)}] <= {bus.din_re[k], bus.din_im[k]};
         end
      end
   end

   // Write-side control: beat count, drop tracking, bank toggle, overflow
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb      <= '0;
         drop    <= 1'b0;
         wr_bank <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (bus.din_en) begin
            wb <= wb + BEAT_W'(1);
            if (wb == LAST_BEAT) begin
               drop <= 1'b0;
               if (!drop_now) wr_bank <= ~wr_bank;
            end else if (wb == '0) begin
               drop <= full[wr_bank];
            end
         end
         if (ovf_set)               ovf_q <= 1'b1;
         else if (bus.overflow_clr) ovf_q <= 1'b0;
      end
   end

   // Bank occupancy: writer sets, reader clears, both may act in one edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) full <= '0;
      else       full <= (full & ~full_clr) | full_set;
   end

   // Reader FSM with registered sample, valid and frame markers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         rd_bank  <= 1'b0;
         rd_idx   <= '0;
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
         re_p1    <= '0;
         im_p1    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (full[rd_bank]) begin
                  state          <= STREAM;
                  rd_idx         <= '0;
                  {re_p1, im_p1} <= mem[{rd_bank, {IDX_W{1'b0}}}];
                  vld_p1         <= 1'b1;
                  first_p1       <= 1'b1;
                  last_p1        <= 1'b0;
               end
            end
            STREAM: begin
               if (rd_done) begin
                  rd_bank <= ~rd_bank;
                  rd_idx  <= '0;
                  if (full[~rd_bank]) begin
                     // Other bank already waiting: continue without a bubble
                     {re_p1, im_p1} <= mem[{~rd_bank, {IDX_W{1'b0}}}];
                     first_p1       <= 1'b1;
                     last_p1        <= 1'b0;
                  end else begin
                     state    <= IDLE;
                     vld_p1   <= 1'b0;
                     first_p1 <= 1'b0;
                     last_p1  <= 1'b0;
                  end
               end else if (rd_take) begin
                  rd_idx         <= idx_nxt;
                  {re_p1, im_p1} <= mem[{rd_bank, idx_nxt}];
                  first_p1       <= 1'b0;
                  last_p1        <= (idx_nxt == LAST_IDX);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dout_valid = vld_p1;
   assign bus.dout_re    = re_p1;
   assign bus.dout_im    = im_p1;
   assign bus.dout_first = first_p1;
   assign bus.dout_last  = last_p1;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_fft_out_serializer.sv
// Randomized bench for fft_out_serializer. A frame-level reference model
// (count of stored frames plus a queue of expected samples) predicts
// drops, overflow, output validity and every presented sample.
module tb_fft_out_serializer;
   localparam int WIDTH  = 13;
   localparam int LANES  = 16;
   localparam int NPOINT = 512;
   localparam int BEATS  = NPOINT / LANES;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   fft_out_serializer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

   fft_out_serializer #(.WIDTH(WIDTH), .LANES(LANES), .NPOINT(NPOINT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic signed [WIDTH-1:0] re;
      logic signed [WIDTH-1:0] im;
      int                      idx;
   } samp_t;

   samp_t exp_q[$];
   samp_t cur [NPOINT];
   int    m_wb   = 0;
   int    m_cnt  = 0;
   bit    m_drop = 0;
   bit    m_ovf  = 0;
   bit    exp_vld = 0;

   // At each falling edge: check what the DUT shows now, then predict
   // the effect of the coming rising edge from the current inputs.
   always @(negedge clk) begin : model
      bit    rd_done, wr_done, ovf_set;
      samp_t s;
      if (!rstn) begin
         check_eq("rst_valid", bus.dout_valid, 1'b0);
         check_eq("rst_ovf", bus.overflow, 1'b0);
         exp_q.delete();
         m_wb = 0; m_cnt = 0; m_drop = 0; m_ovf = 0; exp_vld = 0;
      end else begin
         rd_done = 0; wr_done = 0; ovf_set = 0;
         check_eq("valid", bus.dout_valid, exp_vld);
         check_eq("overflow", bus.overflow, m_ovf);
         if (bus.dout_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_sample", 1, 0);
            end else begin
               s = exp_q[0];
               check_eq("re", bus.dout_re, s.re);
               check_eq("im", bus.dout_im, s.im);
               check_eq("first", bus.dout_first, s.idx == 0);
               check_eq("last", bus.dout_last, s.idx == NPOINT - 1);
               if (bus.dout_ready) begin
                  void'(exp_q.pop_front());
                  rd_done = (s.idx == NPOINT - 1);
               end
            end
         end
         if (bus.din_en) begin
            if (m_wb == 0) begin
               m_drop  = (m_cnt == 2);
               ovf_set = m_drop;
            end
            if (!m_drop) begin
               for (int k = 0; k < LANES; k++) begin
                  cur[m_wb*LANES+k].re  = bus.din_re[k];
                  cur[m_wb*LANES+k].im  = bus.din_im[k];
                  cur[m_wb*LANES+k].idx = m_wb*LANES + k;
               end
            end
            if (m_wb == BEATS - 1) begin
               if (!m_drop) begin
                  wr_done = 1;
                  for (int i = 0; i < NPOINT; i++) exp_q.push_back(cur[i]);
               end
               m_drop = 0;
            end
            m_wb = (m_wb + 1) % BEATS;
         end
         if (ovf_set) m_ovf = 1;
         else if (bus.overflow_clr) m_ovf = 0;
         exp_vld = (m_cnt - int'(rd_done)) > 0;
         m_cnt   = m_cnt - int'(rd_done) + int'(wr_done);
      end
   end

   // ---------------- stimulus ----------------
   int rdy_mode = 3;  // 0: always, 1: 1,0,0,1 pattern, 2: random, 3: never

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : ready_drv
      int ph;
      ph = 0;
      bus.dout_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.dout_ready = 1'b1;
            1:       bus.dout_ready = (ph % 4 == 0) || (ph % 4 == 3);
            2:       bus.dout_ready = 1'($urandom % 2);
            default: bus.dout_ready = 1'b0;
         endcase
         ph++;
      end
   end

   // kind 0: ramp pattern, kind 1: random data
   task automatic send_frame(input int kind, input int nbeats, input int gap_at,
                             input int gap_len, input bit rnd, input bit clr0);
      for (int b = 0; b < nbeats; b++) begin
         for (int k = 0; k < LANES; k++) begin
            if (kind == 0) begin
               bus.din_re[k] = WIDTH'(b*LANES + k);
               bus.din_im[k] = WIDTH'(-(b*LANES + k));
            end else begin
               bus.din_re[k] = WIDTH'($urandom);
               bus.din_im[k] = WIDTH'($urandom);
            end
         end
         bus.din_en = 1'b1;
         bus.overflow_clr = (clr0 && b == 0) || (rnd && ($urandom % 16 == 0));
         tick();
         bus.din_en = 1'b0;
         bus.overflow_clr = 1'b0;
         if (b == gap_at) repeat (gap_len) tick();
         if (rnd && ($urandom % 4 == 0)) repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.dout_valid) && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, n < budget, 1'b1);
   endtask

   initial begin : main
      bus.din_en = 1'b0;
      bus.overflow_clr = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         bus.din_re[k] = '0;
         bus.din_im[k] = '0;
      end
      rstn = 1'b0;
      repeat (3) tick();
      check_eq("reset_valid", bus.dout_valid, 1'b0);
      check_eq("reset_re", bus.dout_re, '0);
      check_eq("reset_im", bus.dout_im, '0);
      check_eq("reset_first", bus.dout_first, 1'b0);
      check_eq("reset_last", bus.dout_last, 1'b0);
      check_eq("reset_ovf", bus.overflow, 1'b0);
      rstn = 1'b1;
      tick();

      // ramp frame, consumer always ready
      rdy_mode = 0;
      send_frame(0, BEATS, -1, 0, 0, 0);
      drain("drain_ramp", 2000);

      // ramp frame, ready 1,0,0,1
      rdy_mode = 1;
      send_frame(0, BEATS, -1, 0, 0, 0);
      drain("drain_pattern", 3000);

      // three contiguous frames with no consumer: third is dropped
      rdy_mode = 3;
      repeat (3) send_frame(1, BEATS, -1, 0, 0, 0);
      check_eq("ovf_after_drop", bus.overflow, 1'b1);
      check_eq("hold_valid", bus.dout_valid, 1'b1);
      check_eq("hold_first", bus.dout_first, 1'b1);
      rdy_mode = 0;
      drain("drain_two_frames", 3000);

      // plain clear
      bus.overflow_clr = 1'b1;
      tick();
      bus.overflow_clr = 1'b0;
      check_eq("ovf_cleared", bus.overflow, 1'b0);

      // 5-cycle input gap after beat 10
      send_frame(1, BEATS, 10, 5, 0, 0);
      drain("drain_gap", 2000);

      // reset at beat 20 of a frame while the previous frame streams
      rdy_mode = 2;
      send_frame(1, BEATS, -1, 0, 0, 0);
      send_frame(1, 20, -1, 0, 0, 0);
      check_eq("streaming_before_rst", bus.dout_valid, 1'b1);
      bus.din_en = 1'b1;
      rstn = 1'b0;
      #1;
      check_eq("midrst_valid", bus.dout_valid, 1'b0);
      check_eq("midrst_re", bus.dout_re, '0);
      check_eq("midrst_im", bus.dout_im, '0);
      check_eq("midrst_first", bus.dout_first, 1'b0);
      check_eq("midrst_last", bus.dout_last, 1'b0);
      bus.din_en = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      rdy_mode = 0;
      send_frame(1, BEATS, -1, 0, 0, 0);
      drain("drain_after_rst", 2000);

      // clear coinciding with a drop: set wins
      rdy_mode = 3;
      repeat (2) send_frame(1, BEATS, -1, 0, 0, 0);
      check_eq("ovf_before_coincide", bus.overflow, 1'b0);
      send_frame(1, BEATS, -1, 0, 0, 1);
      check_eq("ovf_set_wins", bus.overflow, 1'b1);
      bus.overflow_clr = 1'b1;
      tick();
      bus.overflow_clr = 1'b0;
      check_eq("ovf_cleared2", bus.overflow, 1'b0);
      rdy_mode = 0;
      drain("drain_coincide", 3000);

      // random traffic: gaps, random ready, random clears
      rdy_mode = 2;
      for (int f = 0; f < 5; f++) begin
         send_frame(1, BEATS, -1, 0, 1, 0);
         repeat ($urandom_range(0, 700)) tick();
      end
      drain("drain_random", 6000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end
endmodule
